// File: rtl/cache_nway_ctrl.sv
// cache_nway_ctrl: N-way set-associative write-back / write-allocate data cache
// with an integrated miss controller. One CPU access in flight at a time.
//
// Ports
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready           CPU request handshake (ready only in IDLE)
//   req_we, req_ubhw              store flag; width {unsigned, word, half}
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid, resp_rdata        one-cycle completion pulse, extended load data
//   mem_req/mem_ack               word-wide memory transfer handshake
//   mem_we, mem_addr, mem_wdata   write-back (we=1) or refill read (we=0)
//   mem_rdata                     refill data, valid with mem_ack
//
// Address split: {tag, index, word, byte}. Miss flow: LOOKUP -> [WBACK] -> REFILL
// -> LOOKUP, so the access always completes through a normal hit.
module cache_nway_ctrl #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_ubhw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int WCNT_W = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0]  OLDEST    = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WBACK, REFILL} state_t;
  state_t state;

  // storage: data/tag not reset, valid/dirty/age reset
  logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];

  // latched request and miss context
  logic              r_we;
  logic [2:0]        r_ubhw;
  logic [31:0]       r_addr, r_wdata;
  logic [WAY_W-1:0]  vict_q;
  logic [WCNT_W-1:0] k_q, k_nxt;
  logic [31:0]       wb_base;

  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WCNT_W-1:0] r_word;
  logic [31:0]       rf_base;

  assign r_tag   = r_addr[31 -: TAG_W];
  assign r_idx   = r_addr[OFF_W +: IDX_W];
  assign r_word  = (LINE_WORDS > 1) ? r_addr[2 +: WCNT_W] : '0;
  assign rf_base = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign k_nxt   = k_q + 1'b1;
  assign req_ready = (state == IDLE);

  // tag compare; at most one way can match since refills only target the victim
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[r_idx][w] && tag_q[w][r_idx] == r_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  // victim: lowest invalid way, else the oldest
  logic             any_inv;
  logic [WAY_W-1:0] vict;
  always_comb begin
    vict    = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[r_idx][w]) begin
        vict    = WAY_W'(w);
        any_inv = 1'b1;
      end
    if (!any_inv)
      for (int w = 0; w < WAYS; w++)
        if (age_q[r_idx][w] == OLDEST) vict = WAY_W'(w);
  end

  logic [31:0]      hword;
  logic [WAY_W-1:0] hit_age;
  assign hword   = data_q[hit_way][r_idx][r_word];
  assign hit_age = age_q[r_idx][hit_way];

  // load extract and sign/zero extend
  logic [15:0] hval;
  logic [7:0]  bval;
  logic [31:0] ld_data;
  always_comb begin
    hval = r_addr[1] ? hword[31:16] : hword[15:0];
    bval = hword[{r_addr[1:0], 3'b000} +: 8];
    if (r_ubhw[1])      ld_data = hword;
    else if (r_ubhw[0]) ld_data = r_ubhw[2] ? {16'h0, hval} : {{16{hval[15]}}, hval};
    else                ld_data = r_ubhw[2] ? {24'h0, bval} : {{24{bval[7]}}, bval};
  end

  // store byte-lane merge
  logic [31:0] st_mask, st_data, merged;
  always_comb begin
    if (r_ubhw[1]) begin
      st_mask = '1;
      st_data = r_wdata;
    end else if (r_ubhw[0]) begin
      st_mask = r_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      st_data = {2{r_wdata[15:0]}};
    end else begin
      st_mask = 32'h0000_00FF << {r_addr[1:0], 3'b000};
      st_data = {4{r_wdata[7:0]}};
    end
    merged = (hword & ~st_mask) | (st_data & st_mask);
  end

  logic st_wr, rf_wr, rf_last;
  assign st_wr   = (state == LOOKUP) && hit && r_we;
  assign rf_wr   = (state == REFILL) && mem_ack;
  assign rf_last = rf_wr && (k_q == LAST_WORD);

  // data and tag arrays (no reset; state reset blocks all writes)
  always_ff @(posedge clk) begin
    if (st_wr)   data_q[hit_way][r_idx][r_word] <= merged;
    if (rf_wr)   data_q[vict_q][r_idx][k_q]     <= mem_rdata;
    if (rf_last) tag_q[vict_q][r_idx]           <= r_tag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_ubhw     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      vict_q     <= '0;
      k_q        <= '0;
      wb_base    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_ubhw  <= req_ubhw;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          state   <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= r_we ? '0 : ld_data;
          if (r_we) dirty_q[r_idx][hit_way] <= 1'b1;
          for (int w = 0; w < WAYS; w++)
            if (WAY_W'(w) == hit_way)        age_q[r_idx][w] <= '0;
            else if (age_q[r_idx][w] < hit_age) age_q[r_idx][w] <= age_q[r_idx][w] + 1'b1;
        end else begin
          vict_q  <= vict;
          k_q     <= '0;
          mem_req <= 1'b1;
          // invalidate up front so an aborted transfer never leaves a half line valid
          valid_q[r_idx][vict] <= 1'b0;
          wb_base <= {tag_q[vict][r_idx], r_idx, {OFF_W{1'b0}}};
          if (valid_q[r_idx][vict] && dirty_q[r_idx][vict]) begin
            state     <= WBACK;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_q[vict][r_idx], r_idx, {OFF_W{1'b0}}};
            mem_wdata <= data_q[vict][r_idx][0];
          end else begin
            state     <= REFILL;
            mem_we    <= 1'b0;
            mem_addr  <= rf_base;
            mem_wdata <= '0;
          end
        end
        WBACK: if (mem_ack) begin
          if (k_q == LAST_WORD) begin
            state     <= REFILL;
            k_q       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= rf_base;
            mem_wdata <= '0;
          end else begin
            k_q       <= k_nxt;
            mem_addr  <= wb_base | 32'({k_nxt, 2'b00});
            mem_wdata <= data_q[vict_q][r_idx][k_nxt];
          end
        end
        REFILL: if (mem_ack) begin
          if (k_q == LAST_WORD) begin
            state    <= LOOKUP;
            k_q      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            valid_q[r_idx][vict_q] <= 1'b1;
            dirty_q[r_idx][vict_q] <= 1'b0;
            // new line enters as oldest; the replay hit then promotes it and
            // ages every other way, keeping ages a permutation as ways fill
            age_q[r_idx][vict_q] <= OLDEST;
          end else begin
            k_q      <= k_nxt;
            mem_addr <= rf_base | 32'({k_nxt, 2'b00});
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Scoreboard bench for cache_nway_ctrl: stimulus pushes expected CPU responses
// and memory transfers; a CPU monitor and a memory responder pop and compare.
module tb_cache_nway_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_we;
  logic [2:0]  req_ubhw;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  cache_nway_ctrl #(.WAYS(2), .SETS(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_ubhw(req_ubhw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct { logic [31:0] rdata; int lat; int drv_cyc; string name; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } memop_t;
  resp_t  exp_resp[$];
  memop_t exp_mem[$];

  int tests = 0, fails = 0;
  int mem_lat = 1, acks = 0, resp_seen = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    memop_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    exp_mem.push_back(m);
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) push_mem(1'b0, base + 32'(4 * k), 32'h0);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic drive(input logic we, input logic [2:0] ubhw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input int lat,
                       input string nm);
    resp_t r;
    req_valid = 1'b1; req_we = we; req_ubhw = ubhw; req_addr = addr; req_wdata = wdata;
    r.rdata = exp; r.lat = lat; r.drv_cyc = pcyc; r.name = nm;
    exp_resp.push_back(r);
    @(negedge clk);
    // junk on the request bus after accept must be ignored
    req_valid = 1'b0; req_we = ~we; req_ubhw = 3'b111; req_addr = ~addr; req_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic access(input logic we, input logic [2:0] ubhw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input int lat,
                        input string nm);
    int n = 0;
    wait_ready();
    drive(we, ubhw, addr, wdata, exp, lat, nm);
    while (exp_resp.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (exp_resp.size() != 0) begin
      chk({nm, "_resp_timeout"}, 32'(exp_resp.size()), 32'h0);
      exp_resp.delete();
    end
    chk({nm, "_mem_pending"}, 32'(exp_mem.size()), 32'h0);
  endtask

  // CPU response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        resp_seen++;
        if (exp_resp.size() == 0) chk("resp_unexpected", 32'h1, 32'h0);
        else begin
          r = exp_resp.pop_front();
          chk(r.name, resp_rdata, r.rdata);
          if (r.lat > 0) chk({r.name, "_lat"}, 32'(pcyc - r.drv_cyc), 32'(r.lat));
        end
      end
    end
  end

  // memory responder: returns addr ^ A5A5_0000, checks order and hold stability
  initial begin
    memop_t m;
    logic busy, stable_ok, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    int wcnt;
    busy = 1'b0; stable_ok = 1'b1; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; wcnt = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst !== 1'b1 || mem_req !== 1'b1) busy = 1'b0;
      else begin
        if (!busy) begin
          busy = 1'b1; wcnt = 0; stable_ok = 1'b1;
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
          if (exp_mem.size() == 0) chk("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
          else begin
            m = exp_mem.pop_front();
            chk("mem_we", {31'h0, mem_we}, {31'h0, m.we});
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          end
        end else if (mem_we !== cap_we || mem_addr !== cap_addr ||
                     (cap_we && mem_wdata !== cap_wdata) || req_ready !== 1'b0)
          stable_ok = 1'b0;
        if (wcnt == mem_lat) begin
          mem_ack = 1'b1;
          mem_rdata = cap_addr ^ 32'hA5A5_0000;
          busy = 1'b0;
          acks++;
          if (mem_lat > 0) chk("mem_hold", {31'h0, stable_ok}, 32'h1);
        end else wcnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_acks, seen0;
    req_valid = 1'b0; req_we = 1'b0; req_ubhw = '0; req_addr = '0; req_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_req",    {31'h0, mem_req},    32'h0);
    chk("rst_mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst_mem_addr",   mem_addr,  32'h0);
    chk("rst_mem_wdata",  mem_wdata, 32'h0);
    rst = 1'b1;

    // 1: cold miss refill, then hit
    push_line(32'h40);
    access(1'b0, LW, 32'h0000_0040, 32'h0, 32'hA5A5_0040, 0, "t1_lw40_miss");
    access(1'b0, LW, 32'h0000_0048, 32'h0, 32'hA5A5_0048, 2, "t1_lw48_hit");

    // 2: load widths / extension
    access(1'b1, SW,  32'h40, 32'h1234_8081, 32'h0, 2, "t2_sw40");
    access(1'b0, LB,  32'h43, 32'h0, 32'h0000_0012, 2, "t2_lb43");
    access(1'b0, LB,  32'h40, 32'h0, 32'hFFFF_FF81, 2, "t2_lb40");
    access(1'b0, LBU, 32'h40, 32'h0, 32'h0000_0081, 2, "t2_lbu40");
    access(1'b0, LH,  32'h42, 32'h0, 32'h0000_1234, 2, "t2_lh42");
    access(1'b0, LHU, 32'h40, 32'h0, 32'h0000_8081, 2, "t2_lhu40");
    access(1'b0, LH,  32'h40, 32'h0, 32'hFFFF_8081, 2, "t2_lh40");

    // 3: half store merge, byte store merge
    access(1'b1, SH, 32'h42, 32'h0000_BEEF, 32'h0, 2, "t3_sh42");
    access(1'b0, LW, 32'h40, 32'h0, 32'hBEEF_8081, 2, "t3_lw40");
    access(1'b1, SB, 32'h4D, 32'h0000_0077, 32'h0, 2, "t3_sb4d");
    access(1'b0, LW, 32'h4C, 32'h0, 32'hA5A5_774C, 2, "t3_lw4c");

    // 4: A=0x040, B=0x240, C=0x440 share set 4; dirty B is evicted by C
    access(1'b0, LW, 32'h040, 32'h0, 32'hBEEF_8081, 2, "t4_ldA");
    push_line(32'h240);
    access(1'b1, SW, 32'h240, 32'hCAFE_F00D, 32'h0, 0, "t4_stB");
    access(1'b0, LW, 32'h040, 32'h0, 32'hBEEF_8081, 2, "t4_ldA2");
    push_mem(1'b1, 32'h240, 32'hCAFE_F00D);
    push_mem(1'b1, 32'h244, 32'hA5A5_0244);
    push_mem(1'b1, 32'h248, 32'hA5A5_0248);
    push_mem(1'b1, 32'h24C, 32'hA5A5_024C);
    push_line(32'h440);
    access(1'b0, LW, 32'h440, 32'h0, 32'hA5A5_0440, 0, "t4_ldC");
    access(1'b0, LW, 32'h04C, 32'h0, 32'hA5A5_774C, 2, "t4_ldA3");

    // 5: slow memory, request must hold
    mem_lat = 5;
    push_line(32'h1080);
    access(1'b0, LW, 32'h1084, 32'h0, 32'hA5A5_1084, 0, "t5_slow");

    // 6: reset during second refill word
    mem_lat = 2;
    push_line(32'h2090);
    base_acks = acks;
    wait_ready();
    drive(1'b0, LW, 32'h2094, 32'h0, 32'hA5A5_2094, 0, "t6_aborted");
    n = 0;
    while (acks < base_acks + 1 && n < 100) begin @(negedge clk); n++; end
    chk("t6_first_ack", 32'(acks - base_acks), 32'h1);
    @(posedge clk); #2;
    chk("t6_pre_req",  {31'h0, mem_req}, 32'h1);
    chk("t6_pre_addr", mem_addr, 32'h2094);
    rst = 1'b0;
    #1;
    chk("t6_rst_req",  {31'h0, mem_req}, 32'h0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    exp_resp.delete();
    exp_mem.delete();
    seen0 = resp_seen;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_resp", 32'(resp_seen - seen0), 32'h0);
    chk("t6_ready",   {31'h0, req_ready}, 32'h1);
    push_line(32'h2090);
    access(1'b0, LW, 32'h2094, 32'h0, 32'hA5A5_2094, 0, "t6_refill");
    // earlier lines were dropped by the reset
    push_line(32'h40);
    access(1'b0, LW, 32'h40, 32'h0, 32'hA5A5_0040, 0, "t6_lw40_miss");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
